gpu_kernel_dispatcher: RTL and testbench
========================================

Name: gpu_kernel_dispatcher

Overview:
Host-facing launch controller directly upstream of the GPU top level. It queues kernel launch commands and runs them one at a time: reset the GPU array, pulse `start`, wait for `done` or a timeout, then post a completion record. It drives the GPU's `reset`/`start` and consumes its `done` and `instructions_completed` outputs.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- KID_WIDTH, 8, kernel ID width.
- RESET_CYCLES, 2, cycles `gpu_reset` is held per launch (≥1).
- TIMEOUT_CYCLES, 1024, max WAIT_DONE cycles before abort (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  launch command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_kernel_id  in  KID_WIDTH  tag of the launch.
- gpu_reset  out  1  reset to GPU array.
- gpu_start  out  1  one-cycle start pulse to GPU array.
- gpu_done  in  1  all GPU threads done.
- gpu_instructions  in  16  GPU `instructions_completed` counter.
- cpl_valid  out  1  completion record valid.
- cpl_ready  in  1  consumer accepts record.
- cpl_kernel_id  out  KID_WIDTH  tag of the completed launch.
- cpl_cycles  out  32  WAIT_DONE cycles consumed.
- cpl_instructions  out  16  `gpu_instructions` sampled at completion.
- cpl_timeout  out  1  1 = aborted by timeout.
- busy  out  1  state ≠ IDLE or FIFO non-empty.
- launches_done  out  16  completion records accepted, wraps at 0xFFFF→0.

Behaviour:
- Reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - `gpu_reset` = 1; every other output = 0.
  - `cmd_ready` = 1 one cycle after reset deasserts; state = IDLE; FIFO empty.
- FIFO:
  - `cmd_ready` = !full. A push occurs on any edge with `cmd_valid && cmd_ready`.
  - A pop occurs only on the IDLE→GPU_RST transition.
  - Push and pop on the same edge are both performed; count is unchanged.
  - Pointers wrap modulo CMD_DEPTH.
  - A `cmd_valid` held while full is not accepted and causes no corruption.
- FSM states: IDLE, GPU_RST, START, WAIT_DONE, REPORT.
- IDLE:
  - `gpu_reset` = 0.
  - If the FIFO is non-empty, pop, latch the kernel ID and go to GPU_RST.
  - A command pushed at edge E0 into an empty FIFO is popped at E1.
- GPU_RST:
  - `gpu_reset` = 1 for exactly RESET_CYCLES cycles, then go to START.
- START:
  - `gpu_reset` = 0 and `gpu_start` = 1 for exactly one cycle.
  - Clear the cycle counter, then go to WAIT_DONE.
- WAIT_DONE:
  - Counter increments each edge.
  - If `gpu_done` is sampled high at the k-th WAIT_DONE edge: `cpl_cycles` = k, `cpl_timeout` = 0, capture `gpu_instructions`, go to REPORT.
  - Otherwise, if k == TIMEOUT_CYCLES: `cpl_cycles` = TIMEOUT_CYCLES, `cpl_timeout` = 1, capture `gpu_instructions`, go to REPORT.
  - `done` and timeout on the same edge: `done` wins, `cpl_timeout` = 0.
- REPORT:
  - `cpl_valid` = 1. All `cpl_*` fields are held stable until `cpl_valid && cpl_ready`.
  - On that handshake: `launches_done` increments, `cpl_valid` → 0 next cycle, go to IDLE.
  - `gpu_done` is ignored in REPORT.
- `gpu_start` is never asserted while `gpu_reset` = 1.
- A `gpu_done` level stuck high is only evaluated in WAIT_DONE, which always follows GPU_RST.
- Reset mid-operation:
  - Immediately forces `gpu_reset` = 1 and `gpu_start` = 0.
  - Flushes the FIFO and drops any pending completion; `launches_done` = 0.
- Counter is 32-bit; TIMEOUT_CYCLES bounds it, so no overflow.

Test Plan:
- RESET_CYCLES=2. Push ID 0x11 at E0, `gpu_done` high at the 5th WAIT_DONE edge, `cpl_ready` = 1 → `gpu_reset` high after E1–E2; `gpu_start` high E3–E4; `cpl_valid` with id 0x11, cycles 5, timeout 0; `launches_done` = 1.
- TIMEOUT_CYCLES=64, `gpu_done` never asserted → completion with cycles 64, timeout 1; `gpu_start` pulsed exactly once.
- Push 5 commands back-to-back with CMD_DEPTH=4 while busy → `cmd_ready` low after the 4th queued entry; all 5 complete in order, `launches_done` = 5.
- Hold `cpl_ready` = 0 for 10 cycles in REPORT, toggle `gpu_done` → record stable, no new `gpu_start`, FIFO accepts pushes while not full.
- `gpu_done` and timeout on the same edge (done at the 64th edge) → cycles 64, timeout 0.
- Assert reset during WAIT_DONE with 2 queued commands → `gpu_reset` = 1 asynchronously, `busy` = 0, `cpl_valid` = 0, `launches_done` = 0 after release; no stale launch.

Source files
------------

// File: rtl/gpu_kernel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : gpu_kernel_dispatcher
// Description : Queues kernel launch commands and runs them one at a time on
//               the GPU array: reset the array, pulse start, wait for done or
//               a timeout, then post a completion record to the host.
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_kernel_dispatcher #(
    parameter int CMD_DEPTH      = 4,
    parameter int KID_WIDTH      = 8,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [KID_WIDTH-1:0] cmd_kernel_id,
    output logic                 gpu_reset,
    output logic                 gpu_start,
    input  logic                 gpu_done,
    input  logic [15:0]          gpu_instructions,
    output logic                 cpl_valid,
    input  logic                 cpl_ready,
    output logic [KID_WIDTH-1:0] cpl_kernel_id,
    output logic [31:0]          cpl_cycles,
    output logic [15:0]          cpl_instructions,
    output logic                 cpl_timeout,
    output logic                 busy,
    output logic [15:0]          launches_done
);

    localparam int c_AW = $clog2(CMD_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_RW = $clog2(RESET_CYCLES + 1);

    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(CMD_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_RW-1:0] c_RST_LAST = c_RW'(RESET_CYCLES - 1);
    localparam logic [c_RW-1:0] c_RST_ONE  = c_RW'(1);
    localparam logic [31:0]     c_TIMEOUT  = 32'(TIMEOUT_CYCLES);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_GPU_RST   = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ST_REPORT    = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;

    logic [KID_WIDTH-1:0] r_mem [CMD_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;
    logic [c_CW-1:0]      w_count_next;

    logic [KID_WIDTH-1:0] r_cur_kid;
    logic [c_RW-1:0]      r_rst_cnt;
    logic [31:0]          r_cycles;

    logic                 r_cmd_ready;
    logic                 r_gpu_reset;
    logic                 r_gpu_start;
    logic                 r_cpl_valid;
    logic [KID_WIDTH-1:0] r_cpl_kid;
    logic [31:0]          r_cpl_cycles;
    logic [15:0]          r_cpl_instr;
    logic                 r_cpl_timeout;
    logic                 r_busy;
    logic [15:0]          r_launches;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_cpl_hs;
    logic [31:0]          w_wait_k;
    logic                 w_wait_end;

    assign w_push     = cmd_valid && r_cmd_ready;
    assign w_pop      = (r_state == c_ST_IDLE) && (r_count != '0);
    assign w_cpl_hs   = r_cpl_valid && cpl_ready;
    assign w_wait_k   = r_cycles + 32'd1;
    assign w_wait_end = gpu_done || (w_wait_k == c_TIMEOUT);

    assign cmd_ready        = r_cmd_ready;
    assign gpu_reset        = r_gpu_reset;
    assign gpu_start        = r_gpu_start;
    assign cpl_valid        = r_cpl_valid;
    assign cpl_kernel_id    = r_cpl_kid;
    assign cpl_cycles       = r_cpl_cycles;
    assign cpl_instructions = r_cpl_instr;
    assign cpl_timeout      = r_cpl_timeout;
    assign busy             = r_busy;
    assign launches_done    = r_launches;

    // FIFO occupancy after this edge; simultaneous push and pop cancel out
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    // Launch sequencer next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = c_ST_GPU_RST;
                end
            end
            c_ST_GPU_RST: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                w_next_state = c_ST_WAIT_DONE;
            end
            c_ST_WAIT_DONE: begin
                if (w_wait_end) begin
                    w_next_state = c_ST_REPORT;
                end
            end
            c_ST_REPORT: begin
                if (w_cpl_hs) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_kernel_id;
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued launches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    // Launch counters, completion record and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_kid     <= '0;
            r_rst_cnt     <= '0;
            r_cycles      <= '0;
            r_cmd_ready   <= 1'b0;
            r_gpu_reset   <= 1'b1;
            r_gpu_start   <= 1'b0;
            r_cpl_valid   <= 1'b0;
            r_cpl_kid     <= '0;
            r_cpl_cycles  <= '0;
            r_cpl_instr   <= '0;
            r_cpl_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_launches    <= '0;
        end else begin
            r_cmd_ready <= (w_count_next != c_DEPTH);
            r_busy      <= (w_next_state != c_ST_IDLE) || (w_count_next != '0);
            r_gpu_reset <= (w_next_state == c_ST_GPU_RST);
            r_gpu_start <= (w_next_state == c_ST_START);

            if (w_pop) begin
                r_cur_kid <= r_mem[r_rd_ptr];
                r_rst_cnt <= '0;
            end

            if ((r_state == c_ST_GPU_RST) && (w_next_state == c_ST_GPU_RST)) begin
                r_rst_cnt <= r_rst_cnt + c_RST_ONE;
            end

            if (r_state == c_ST_START) begin
                r_cycles <= '0;
            end

            // On completion k already equals TIMEOUT_CYCLES when timing out
            if (r_state == c_ST_WAIT_DONE) begin
                if (w_wait_end) begin
                    r_cpl_valid   <= 1'b1;
                    r_cpl_kid     <= r_cur_kid;
                    r_cpl_cycles  <= w_wait_k;
                    r_cpl_instr   <= gpu_instructions;
                    r_cpl_timeout <= !gpu_done;
                end else begin
                    r_cycles <= w_wait_k;
                end
            end

            if (w_cpl_hs) begin
                r_cpl_valid <= 1'b0;
                r_launches  <= r_launches + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gpu_kernel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_kernel_dispatcher
// Description : Self-checking bench for gpu_kernel_dispatcher. A queue-based
//               reference model tracks queued commands, the active launch and
//               its phase, and predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_kernel_dispatcher;

    localparam int P_DEPTH = 4;
    localparam int P_KID   = 8;
    localparam int P_RST   = 2;
    localparam int P_TO    = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [P_KID-1:0] cmd_kernel_id;
    logic             gpu_reset;
    logic             gpu_start;
    logic             gpu_done;
    logic [15:0]      gpu_instructions;
    logic             cpl_valid;
    logic             cpl_ready;
    logic [P_KID-1:0] cpl_kernel_id;
    logic [31:0]      cpl_cycles;
    logic [15:0]      cpl_instructions;
    logic             cpl_timeout;
    logic             busy;
    logic [15:0]      launches_done;

    gpu_kernel_dispatcher #(
        .CMD_DEPTH      (P_DEPTH),
        .KID_WIDTH      (P_KID),
        .RESET_CYCLES   (P_RST),
        .TIMEOUT_CYCLES (P_TO)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_kernel_id    (cmd_kernel_id),
        .gpu_reset        (gpu_reset),
        .gpu_start        (gpu_start),
        .gpu_done         (gpu_done),
        .gpu_instructions (gpu_instructions),
        .cpl_valid        (cpl_valid),
        .cpl_ready        (cpl_ready),
        .cpl_kernel_id    (cpl_kernel_id),
        .cpl_cycles       (cpl_cycles),
        .cpl_instructions (cpl_instructions),
        .cpl_timeout      (cpl_timeout),
        .busy             (busy),
        .launches_done    (launches_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [P_KID-1:0] m_q[$];        // commands accepted but not yet launched
    int               m_dly_q[$];    // forced done delays for upcoming launches
    bit               m_active;      // a launch owns the GPU
    bit               m_in_report;   // completion record outstanding
    bit               m_ready;       // predicted cmd_ready
    bit               m_rst_flag;    // just out of reset, before the first edge
    int               m_since;       // edges since the launch was popped
    int               m_delay;       // WAIT_DONE edge at which the GPU reports done
    logic [P_KID-1:0] m_kid;
    logic [31:0]      m_cyc;
    bit               m_to;
    logic [15:0]      m_instr;
    logic [15:0]      m_launches;
    int               m_starts = 0;
    int               n_start_obs = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int next_delay();
        int r;
        if (m_dly_q.size() > 0) return m_dly_q.pop_front();
        r = $urandom_range(0, 9);
        if (r == 0) return P_TO;
        if (r == 1) return P_TO + 40;
        return $urandom_range(1, 12);
    endfunction

    task automatic check_all();
        check("gpu_reset", gpu_reset, m_rst_flag || (m_active && m_since < P_RST));
        check("gpu_start", gpu_start, m_active && !m_in_report && m_since == P_RST);
        check("cmd_ready", cmd_ready, m_ready);
        check("busy", busy, m_active || (m_q.size() > 0));
        check("cpl_valid", cpl_valid, m_in_report);
        check("launches_done", launches_done, m_launches);
        if (gpu_start) begin
            n_start_obs++;
            check("start_vs_reset", gpu_reset, 1'b0);
        end
        if (m_in_report) begin
            check("cpl_kernel_id", cpl_kernel_id, m_kid);
            check("cpl_cycles", cpl_cycles, m_cyc);
            check("cpl_timeout", cpl_timeout, m_to);
            check("cpl_instructions", cpl_instructions, m_instr);
        end
    endtask

    // One clock: drive the GPU side, advance the model across the edge, check
    task automatic step();
        bit push, pop, hs, in_wait;
        int k;
        gpu_instructions = 16'($urandom);
        in_wait = m_active && !m_in_report && (m_since >= P_RST + 1);
        k = m_since - P_RST;
        if (in_wait) gpu_done = (k == m_delay);
        else         gpu_done = 1'($urandom_range(0, 1));

        push = cmd_valid && m_ready;
        pop  = !m_active && (m_q.size() > 0);
        hs   = m_in_report && cpl_ready;
        if (push) m_q.push_back(cmd_kernel_id);
        if (hs) begin
            m_active    = 1'b0;
            m_in_report = 1'b0;
            m_launches  = m_launches + 16'd1;
        end else if (pop) begin
            m_active = 1'b1;
            m_since  = 0;
            m_kid    = m_q.pop_front();
            m_delay  = next_delay();
        end else if (m_active && !m_in_report) begin
            if (in_wait && (gpu_done || k == P_TO)) begin
                m_in_report = 1'b1;
                m_cyc       = 32'(k);
                m_to        = !gpu_done;
                m_instr     = gpu_instructions;
            end
            m_since++;
            if (m_since == P_RST) m_starts++;
        end
        m_ready    = (m_q.size() != P_DEPTH);
        m_rst_flag = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset starting between clock edges
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_gpu_reset", gpu_reset, 1'b1);
        check("rst_gpu_start", gpu_start, 1'b0);
        check("rst_cpl_valid", cpl_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_launches", launches_done, 16'd0);
        check("rst_cpl_cycles", cpl_cycles, 32'd0);
        m_q.delete();
        m_dly_q.delete();
        m_active    = 1'b0;
        m_in_report = 1'b0;
        m_launches  = 16'd0;
        m_since     = 0;
        cmd_valid   = 1'b0;
        cpl_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        m_rst_flag = 1'b1;
        m_ready    = 1'b0;
        check_all();
        step();
    endtask

    task automatic push_cmd(input logic [P_KID-1:0] kid);
        bit acc;
        int n = 0;
        cmd_valid     = 1'b1;
        cmd_kernel_id = kid;
        do begin
            acc = m_ready;
            step();
            n++;
        end while (!acc && n < 500);
        cmd_valid = 1'b0;
        check("push_budget", {31'd0, acc}, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        cpl_ready = 1'b1;
        while ((m_active || m_q.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        check("drain_budget", m_active || (m_q.size() > 0), 1'b0);
    endtask

    initial begin
        int n;
        reset            = 1'b1;
        cmd_valid        = 1'b0;
        cmd_kernel_id    = '0;
        gpu_done         = 1'b0;
        gpu_instructions = '0;
        cpl_ready        = 1'b0;
        m_launches       = 16'd0;
        @(negedge clk);
        do_reset();

        // Single launch, done at the 5th WAIT_DONE edge
        cpl_ready = 1'b1;
        m_dly_q.push_back(5);
        push_cmd(8'h11);
        repeat (20) step();
        check("t1_launches", launches_done, 16'd1);

        // Timeout, then done coinciding with the timeout edge
        m_dly_q.push_back(P_TO + 100);
        push_cmd(8'h22);
        repeat (80) step();
        m_dly_q.push_back(P_TO);
        push_cmd(8'h33);
        repeat (80) step();
        drain();

        // Back-to-back pushes overfilling the FIFO
        for (int i = 0; i < 6; i++) m_dly_q.push_back(8);
        for (int i = 0; i < 6; i++) push_cmd(8'(8'h40 + i));
        drain();
        check("t3_launches", launches_done, 16'd9);

        // Completion stalled by the consumer while more commands arrive
        cpl_ready = 1'b0;
        m_dly_q.push_back(3);
        push_cmd(8'h55);
        n = 0;
        while (!m_in_report && n < 50) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            cmd_valid     = 1'($urandom_range(0, 1));
            cmd_kernel_id = 8'($urandom);
            step();
        end
        drain();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cmd_valid     = ($urandom_range(0, 2) == 0);
            cmd_kernel_id = 8'($urandom);
            cpl_ready     = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();
        check("start_count", 64'(n_start_obs), 64'(m_starts));

        // Reset in WAIT_DONE with two commands still queued
        cpl_ready = 1'b1;
        m_dly_q.push_back(P_TO + 100);
        push_cmd(8'h90);
        push_cmd(8'h91);
        push_cmd(8'h92);
        n = 0;
        while (!(m_active && m_since >= P_RST + 3) && n < 50) begin
            step();
            n++;
        end
        check("pre_reset_busy", busy, 1'b1);
        do_reset();
        cpl_ready = 1'b1;
        repeat (20) step();
        check("post_reset_start_count", 64'(n_start_obs), 64'(m_starts));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
